uart_command_scheduler: RTL and testbench
=========================================

Name: uart_command_scheduler

Overview:
- Shares one uart_command_accumulator between two UART byte sources: the BLE link (CR-terminated) and the host link (0xBE 0xEF terminated).
- Grants the accumulator to one source per whole command, round-robin.
- Drives the accumulator's input_data, accumulate, ble_side and reset pins with a paced pulse protocol.
- Detects command completion, error or timeout, and hands a command report to the downstream consumer over a valid/ready handshake.

Parameters:
- PULSE_HI, 4: cycles acc_accumulate is held high per byte.
- PULSE_LO, 4: cycles acc_accumulate is held low after each pulse (needed for the accumulator's falling-edge detect).
- BYTE_TIMEOUT, 1000: max cycles waiting for the next byte from the granted source.
- DONE_TIMEOUT, 64: max cycles from the terminator pulse to acc_done.
- MAX_BYTES, 128: byte limit per command, terminator bytes included.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ble_byte  in  8  BLE UART byte
- ble_valid  in  1  ble_byte valid
- ble_ready  out  1  byte accepted when ble_valid&&ble_ready
- host_byte  in  8  host UART byte
- host_valid  in  1  host_byte valid
- host_ready  out  1  host accept
- acc_input_data  out  8  to accumulator input_data
- acc_accumulate  out  1  to accumulator accumulate
- acc_ble_side  out  1  to accumulator ble_side
- acc_reset  out  1  to accumulator reset
- acc_done  in  1  accumulator done
- acc_error  in  1  accumulator error
- cmd_valid  out  1  command report valid
- cmd_ready  in  1  consumer accepts report
- cmd_source  out  1  0=host, 1=BLE
- cmd_error  out  1  command failed (accumulator error, timeout or overflow)
- cmd_bytes  out  8  bytes delivered to the accumulator for this command
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (sync): all outputs 0 except acc_reset=1 for 2 cycles after reset deasserts. FSM=IDLE, rr_last=BLE (host wins the first tie), counters 0.
- States: IDLE, GRANT, WAIT_BYTE, PULSE_HI, PULSE_LO, WAIT_DONE, REPORT, ACC_RST.
- IDLE:
  - If exactly one source is valid, grant it; if both are valid, grant the source not equal to rr_last.
  - Latch owner, set acc_ble_side=owner, then go to GRANT.
  - acc_ble_side changes only in IDLE.
- GRANT: clear byte_cnt, done_low_seen and the timers; go to WAIT_BYTE next cycle.
- WAIT_BYTE:
  - Assert the owner's ready; the other source's ready stays 0.
  - On valid&&ready: register the byte to acc_input_data, byte_cnt+1, go to PULSE_HI.
  - If the byte timer reaches BYTE_TIMEOUT: cmd_error=1, go to REPORT.
- PULSE_HI: acc_accumulate=1 for exactly PULSE_HI cycles; acc_input_data is stable throughout.
- PULSE_LO: acc_accumulate=0 for PULSE_LO cycles, then:
  - byte was terminal: go to WAIT_DONE;
  - byte_cnt==MAX_BYTES and not terminal: cmd_error=1, go to REPORT;
  - otherwise: go to WAIT_BYTE.
- Terminal byte:
  - BLE: 0x0D.
  - Host: 0xEF immediately following 0xBE. After 0xBE the next byte is always forwarded; a non-0xEF byte there is left to the accumulator to flag as error.
- done_low_seen: set whenever acc_done==0 while the scheduler owns the accumulator.
- WAIT_DONE:
  - acc_error=1: cmd_error=1, go to REPORT.
  - acc_done=1 && done_low_seen: success, go to REPORT.
  - Timer reaches DONE_TIMEOUT: cmd_error=1, go to REPORT.
  - Evaluation priority: error > done > timeout.
- acc_error=1 in WAIT_BYTE, PULSE_HI or PULSE_LO aborts immediately to REPORT with cmd_error=1.
- REPORT:
  - cmd_valid=1; cmd_source, cmd_error and cmd_bytes are stable until cmd_valid&&cmd_ready.
  - On acceptance: rr_last=owner.
  - If cmd_error=1, go to ACC_RST; otherwise go to IDLE.
  - cmd_valid drops the cycle after acceptance.
- ACC_RST: acc_reset=1 for 2 cycles, then go to IDLE.
- Source ready is never asserted outside WAIT_BYTE, so no bytes are lost while pulsing.
- Reset mid-command: abandon immediately; no report is issued; the accumulator is reset via acc_reset.
- cmd_bytes counts delivered bytes and saturates at MAX_BYTES.

Test Plan:
- BLE sends 0x41,0x42,0x0D; accumulator model raises done 3 cycles after the last pulse. Required: 3 accumulate pulses, each 4 cycles high and 4 low, acc_ble_side=1; report with cmd_source=1, cmd_error=0, cmd_bytes=3; no acc_reset.
- Host sends 0x10,0xBE,0xEF. Required: acc_ble_side=0; report with cmd_bytes=3, cmd_error=0. Then host sends 0xBE,0x55. Required: the model asserts acc_error, the report has cmd_error=1, and acc_reset pulses 2 cycles.
- Both sources valid in IDLE after reset. Required: host granted first and BLE second; ble_ready stays 0 for the whole host command.
- BLE sends 0x41, then silence. Required: report with cmd_error=1 and cmd_bytes=1 at BYTE_TIMEOUT, followed by acc_reset.
- Host sends 128 non-terminal bytes. Required: report with cmd_error=1 and cmd_bytes=128; the 129th byte is not accepted.
- cmd_ready held 0 for 20 cycles during REPORT. Required: cmd_valid and the report fields stay stable and no new grant occurs; reset asserted mid-byte returns every output to its reset value.

Source files
------------

// File: rtl/uart_command_scheduler.sv
// Shares one command accumulator between the BLE and host UART byte streams,
// granting one whole command at a time round-robin and reporting each outcome.
module uart_command_scheduler #(
    parameter int PULSE_HI     = 4,
    parameter int PULSE_LO     = 4,
    parameter int BYTE_TIMEOUT = 1000,
    parameter int DONE_TIMEOUT = 64,
    parameter int MAX_BYTES    = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ble_byte,
    input  logic       ble_valid,
    output logic       ble_ready,
    input  logic [7:0] host_byte,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [7:0] acc_input_data,
    output logic       acc_accumulate,
    output logic       acc_ble_side,
    output logic       acc_reset,
    input  logic       acc_done,
    input  logic       acc_error,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_source,
    output logic       cmd_error,
    output logic [7:0] cmd_bytes,
    output logic       busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_WAIT_BYTE, S_PULSE_HI,
        S_PULSE_LO, S_WAIT_DONE, S_REPORT, S_ACC_RST
    } state_t;

    localparam logic [7:0]  PH_LAST = 8'(PULSE_HI - 1);
    localparam logic [7:0]  PL_LAST = 8'(PULSE_LO - 1);
    localparam logic [15:0] BT_LAST = 16'(BYTE_TIMEOUT - 1);
    localparam logic [15:0] DT_LAST = 16'(DONE_TIMEOUT - 1);
    localparam logic [7:0]  MAX_CNT = 8'(MAX_BYTES);

    state_t      state_reg;
    logic        owner_reg;          // 1 = BLE owns the accumulator
    logic        rr_last_reg;
    logic [1:0]  init_pend_reg;
    logic [7:0]  pcnt_reg;
    logic [15:0] timer_reg;
    logic [7:0]  byte_cnt_reg;
    logic        term_reg;
    logic        prev_be_reg;
    logic        done_low_seen_reg;
    logic        ble_ready_reg;
    logic        host_ready_reg;
    logic [7:0]  acc_input_data_reg;
    logic        acc_accumulate_reg;
    logic        acc_ble_side_reg;
    logic        acc_reset_reg;
    logic        cmd_valid_reg;
    logic        cmd_source_reg;
    logic        cmd_error_reg;
    logic [7:0]  cmd_bytes_reg;

    logic        src_valid;
    logic [7:0]  src_byte;
    logic        grant_ble;
    logic        byte_terminal;
    logic        go_report;
    logic        report_err;

    assign src_valid     = owner_reg ? ble_valid : host_valid;
    assign src_byte      = owner_reg ? ble_byte : host_byte;
    // On a tie, the source that did not finish last wins
    assign grant_ble     = ble_valid && !(host_valid && rr_last_reg);
    assign byte_terminal = owner_reg ? (src_byte == 8'h0D)
                                     : (prev_be_reg && src_byte == 8'hEF);

    always_comb begin
        go_report  = 1'b0;
        report_err = 1'b1;
        case (state_reg)
            S_WAIT_BYTE: go_report = acc_error || (!src_valid && timer_reg == BT_LAST);
            S_PULSE_HI:  go_report = acc_error;
            S_PULSE_LO:  go_report = acc_error ||
                         (pcnt_reg == PL_LAST && !term_reg && byte_cnt_reg == MAX_CNT);
            S_WAIT_DONE: begin
                if (acc_error) begin
                    go_report = 1'b1;
                end else if (acc_done && done_low_seen_reg) begin
                    go_report  = 1'b1;
                    report_err = 1'b0;
                end else if (timer_reg == DT_LAST) begin
                    go_report = 1'b1;
                end
            end
            default: go_report = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= S_IDLE;
            owner_reg          <= 1'b0;
            rr_last_reg        <= 1'b1;
            init_pend_reg      <= 2'd2;
            pcnt_reg           <= '0;
            timer_reg          <= '0;
            byte_cnt_reg       <= '0;
            term_reg           <= 1'b0;
            prev_be_reg        <= 1'b0;
            done_low_seen_reg  <= 1'b0;
            ble_ready_reg      <= 1'b0;
            host_ready_reg     <= 1'b0;
            acc_input_data_reg <= '0;
            acc_accumulate_reg <= 1'b0;
            acc_ble_side_reg   <= 1'b0;
            acc_reset_reg      <= 1'b0;
            cmd_valid_reg      <= 1'b0;
            cmd_source_reg     <= 1'b0;
            cmd_error_reg      <= 1'b0;
            cmd_bytes_reg      <= '0;
        end else begin
            if (!acc_done && (state_reg == S_WAIT_BYTE || state_reg == S_PULSE_HI ||
                              state_reg == S_PULSE_LO || state_reg == S_WAIT_DONE))
                done_low_seen_reg <= 1'b1;

            if (go_report) begin
                state_reg          <= S_REPORT;
                ble_ready_reg      <= 1'b0;
                host_ready_reg     <= 1'b0;
                acc_accumulate_reg <= 1'b0;
                cmd_valid_reg      <= 1'b1;
                cmd_source_reg     <= owner_reg;
                cmd_error_reg      <= report_err;
                cmd_bytes_reg      <= byte_cnt_reg;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        // Hold the accumulator in reset for two cycles after our own reset
                        if (init_pend_reg != 2'd0) begin
                            acc_reset_reg <= 1'b1;
                            init_pend_reg <= init_pend_reg - 2'd1;
                        end else begin
                            acc_reset_reg <= 1'b0;
                            if (ble_valid || host_valid) begin
                                owner_reg        <= grant_ble;
                                acc_ble_side_reg <= grant_ble;
                                state_reg        <= S_GRANT;
                            end
                        end
                    end
                    S_GRANT: begin
                        byte_cnt_reg      <= '0;
                        done_low_seen_reg <= 1'b0;
                        timer_reg         <= '0;
                        prev_be_reg       <= 1'b0;
                        ble_ready_reg     <= owner_reg;
                        host_ready_reg    <= !owner_reg;
                        state_reg         <= S_WAIT_BYTE;
                    end
                    S_WAIT_BYTE: begin
                        if (src_valid) begin
                            acc_input_data_reg <= src_byte;
                            acc_accumulate_reg <= 1'b1;
                            term_reg           <= byte_terminal;
                            prev_be_reg        <= (src_byte == 8'hBE) && !owner_reg;
                            if (byte_cnt_reg != MAX_CNT)
                                byte_cnt_reg <= byte_cnt_reg + 8'd1;
                            ble_ready_reg      <= 1'b0;
                            host_ready_reg     <= 1'b0;
                            pcnt_reg           <= '0;
                            state_reg          <= S_PULSE_HI;
                        end else begin
                            timer_reg <= timer_reg + 16'd1;
                        end
                    end
                    S_PULSE_HI: begin
                        if (pcnt_reg == PH_LAST) begin
                            acc_accumulate_reg <= 1'b0;
                            pcnt_reg           <= '0;
                            state_reg          <= S_PULSE_LO;
                        end else begin
                            pcnt_reg <= pcnt_reg + 8'd1;
                        end
                    end
                    S_PULSE_LO: begin
                        if (pcnt_reg == PL_LAST) begin
                            timer_reg <= '0;
                            if (term_reg) begin
                                state_reg <= S_WAIT_DONE;
                            end else begin
                                ble_ready_reg  <= owner_reg;
                                host_ready_reg <= !owner_reg;
                                state_reg      <= S_WAIT_BYTE;
                            end
                        end else begin
                            pcnt_reg <= pcnt_reg + 8'd1;
                        end
                    end
                    S_WAIT_DONE: timer_reg <= timer_reg + 16'd1;
                    S_REPORT: begin
                        if (cmd_ready) begin
                            cmd_valid_reg <= 1'b0;
                            rr_last_reg   <= owner_reg;
                            if (cmd_error_reg) begin
                                acc_reset_reg <= 1'b1;
                                pcnt_reg      <= '0;
                                state_reg     <= S_ACC_RST;
                            end else begin
                                state_reg <= S_IDLE;
                            end
                        end
                    end
                    S_ACC_RST: begin
                        if (pcnt_reg == 8'd1) begin
                            acc_reset_reg <= 1'b0;
                            state_reg     <= S_IDLE;
                        end else begin
                            pcnt_reg <= pcnt_reg + 8'd1;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign ble_ready      = ble_ready_reg;
    assign host_ready     = host_ready_reg;
    assign acc_input_data = acc_input_data_reg;
    assign acc_accumulate = acc_accumulate_reg;
    assign acc_ble_side   = acc_ble_side_reg;
    assign acc_reset      = acc_reset_reg;
    assign cmd_valid      = cmd_valid_reg;
    assign cmd_source     = cmd_source_reg;
    assign cmd_error      = cmd_error_reg;
    assign cmd_bytes      = cmd_bytes_reg;
    assign busy           = (state_reg != S_IDLE);
endmodule

// File: tb/tb_uart_command_scheduler.sv
// Directed bench for uart_command_scheduler with a small behavioural accumulator.
module tb_uart_command_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ble_byte = '0;
    logic       ble_valid = 1'b0;
    logic       ble_ready;
    logic [7:0] host_byte = '0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [7:0] acc_input_data;
    logic       acc_accumulate;
    logic       acc_ble_side;
    logic       acc_reset;
    logic       acc_done = 1'b0;
    logic       acc_error = 1'b0;
    logic       cmd_valid;
    logic       cmd_ready = 1'b1;
    logic       cmd_source;
    logic       cmd_error;
    logic [7:0] cmd_bytes;
    logic       busy;

    uart_command_scheduler dut (
        .clk(clk), .reset(reset),
        .ble_byte(ble_byte), .ble_valid(ble_valid), .ble_ready(ble_ready),
        .host_byte(host_byte), .host_valid(host_valid), .host_ready(host_ready),
        .acc_input_data(acc_input_data), .acc_accumulate(acc_accumulate),
        .acc_ble_side(acc_ble_side), .acc_reset(acc_reset),
        .acc_done(acc_done), .acc_error(acc_error),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_source(cmd_source),
        .cmd_error(cmd_error), .cmd_bytes(cmd_bytes), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [24:0] all_outs;
    assign all_outs = {ble_ready, host_ready, acc_input_data, acc_accumulate, acc_ble_side,
                       acc_reset, cmd_valid, cmd_source, cmd_error, cmd_bytes, busy};

    logic [7:0] ble_buf [256];
    logic [7:0] host_buf [256];

    // Accumulator model and observation counters, all sampled on the falling edge
    int pulse_cnt, hi_min, hi_max, lo_min, hi_len, lo_len, side_bad, data_bad;
    int rst_cycles, ready_bad, done_cd, side_exp;
    bit have_fall, prev_be_m;
    logic prev_acc = 1'b0;
    logic [7:0] cur_byte;

    int rep_cnt = 0;
    logic       rep_src [16];
    logic       rep_err [16];
    logic [7:0] rep_bytes [16];

    always @(negedge clk) begin
        if (acc_reset) begin
            acc_done = 1'b0; acc_error = 1'b0; prev_be_m = 1'b0; done_cd = 0;
            rst_cycles++;
        end
        if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) acc_done = 1'b1;
        end
        if (acc_accumulate && !prev_acc) begin
            acc_done = 1'b0;
            pulse_cnt++;
            cur_byte = acc_input_data;
            hi_len = 1;
            if (side_exp >= 0 && acc_ble_side !== side_exp[0]) side_bad++;
            if (have_fall && lo_len < lo_min) lo_min = lo_len;
        end else if (acc_accumulate) begin
            hi_len++;
            if (acc_input_data !== cur_byte) data_bad++;
        end else if (prev_acc) begin
            if (hi_len < hi_min) hi_min = hi_len;
            if (hi_len > hi_max) hi_max = hi_len;
            lo_len = 1;
            have_fall = 1'b1;
            if (acc_ble_side) begin
                if (cur_byte == 8'h0D) done_cd = 3;
            end else if (prev_be_m) begin
                if (cur_byte == 8'hEF) done_cd = 3;
                else acc_error = 1'b1;
                prev_be_m = 1'b0;
            end else begin
                prev_be_m = (cur_byte == 8'hBE);
            end
        end else begin
            lo_len++;
        end
        prev_acc = acc_accumulate;
        if (busy && ((ble_ready && !acc_ble_side) || (host_ready && acc_ble_side))) ready_bad++;
        if (cmd_valid && cmd_ready && rep_cnt < 16) begin
            rep_src[rep_cnt] = cmd_source;
            rep_err[rep_cnt] = cmd_error;
            rep_bytes[rep_cnt] = cmd_bytes;
            rep_cnt++;
        end
    end

    task automatic clear_stats(input int side);
        pulse_cnt = 0; hi_min = 1000; hi_max = 0; lo_min = 1000; have_fall = 1'b0;
        side_bad = 0; data_bad = 0; rst_cycles = 0; ready_bad = 0; side_exp = side;
    endtask

    task automatic send_ble(input int n, input int budget, output int sent);
        bit got;
        sent = 0;
        for (int i = 0; i < n; i++) begin
            ble_byte = ble_buf[i]; ble_valid = 1'b1; got = 1'b0;
            for (int c = 0; c < budget && !got; c++) begin
                @(negedge clk);
                if (ble_ready) got = 1'b1;
            end
            if (!got) break;
            @(posedge clk); #1;
            sent++;
        end
        ble_valid = 1'b0;
    endtask

    task automatic send_host(input int n, input int budget, output int sent);
        bit got;
        sent = 0;
        for (int i = 0; i < n; i++) begin
            host_byte = host_buf[i]; host_valid = 1'b1; got = 1'b0;
            for (int c = 0; c < budget && !got; c++) begin
                @(negedge clk);
                if (host_ready) got = 1'b1;
            end
            if (!got) break;
            @(posedge clk); #1;
            sent++;
        end
        host_valid = 1'b0;
    endtask

    task automatic wait_reports(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (rep_cnt >= target) ok = 1'b1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; ble_valid = 1'b0; host_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rst_cycles = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_outs !== 25'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        @(posedge clk); #1 reset = 1'b0;
        rst_cycles = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (rst_cycles != 2) begin
            errors++; $display("FAIL reset_acc_reset_len: got %0d expected 2", rst_cycles);
        end
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b cmd_valid=%b expected 0 0", busy, cmd_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_ble_command();
        int sent, base; bit ok;
        clear_stats(1);
        base = rep_cnt;
        ble_buf[0] = 8'h41; ble_buf[1] = 8'h42; ble_buf[2] = 8'h0D;
        send_ble(3, 100, sent);
        wait_reports(base + 1, 200, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (sent != 3 || !ok) begin
            errors++; $display("FAIL ble_handshake: sent=%0d report=%b expected 3 1", sent, ok);
        end else begin
            checks++;
            if (rep_src[base] !== 1'b1 || rep_err[base] !== 1'b0 || rep_bytes[base] !== 8'd3) begin
                errors++;
                $display("FAIL ble_report: src=%b err=%b bytes=%0d expected 1 0 3",
                         rep_src[base], rep_err[base], rep_bytes[base]);
            end
        end
        checks++;
        if (pulse_cnt != 3) begin
            errors++; $display("FAIL ble_pulse_count: got %0d expected 3", pulse_cnt);
        end
        checks++;
        if (hi_min != 4 || hi_max != 4) begin
            errors++; $display("FAIL ble_pulse_high: min=%0d max=%0d expected 4 4", hi_min, hi_max);
        end
        checks++;
        if (lo_min < 4 || lo_min == 1000) begin
            errors++; $display("FAIL ble_pulse_low: min=%0d expected >=4", lo_min);
        end
        checks++;
        if (side_bad != 0 || data_bad != 0) begin
            errors++; $display("FAIL ble_side_data: side_bad=%0d data_bad=%0d expected 0 0", side_bad, data_bad);
        end
        checks++;
        if (rst_cycles != 0) begin
            errors++; $display("FAIL ble_no_acc_reset: got %0d expected 0", rst_cycles);
        end
        $display("test_ble_command: sent=%0d reports=%0d", sent, rep_cnt - base);
    endtask

    task automatic test_host_command();
        int sent, base; bit ok;
        clear_stats(0);
        base = rep_cnt;
        host_buf[0] = 8'h10; host_buf[1] = 8'hBE; host_buf[2] = 8'hEF;
        send_host(3, 100, sent);
        wait_reports(base + 1, 200, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || rep_src[base] !== 1'b0 || rep_err[base] !== 1'b0 || rep_bytes[base] !== 8'd3) begin
            errors++;
            $display("FAIL host_report: ok=%b src=%b err=%b bytes=%0d expected 1 0 0 3",
                     ok, rep_src[base], rep_err[base], rep_bytes[base]);
        end
        checks++;
        if (side_bad != 0 || pulse_cnt != 3 || rst_cycles != 0) begin
            errors++;
            $display("FAIL host_side: side_bad=%0d pulses=%0d resets=%0d expected 0 3 0",
                     side_bad, pulse_cnt, rst_cycles);
        end
        $display("test_host_command ok: sent=%0d", sent);

        clear_stats(0);
        host_buf[0] = 8'hBE; host_buf[1] = 8'h55;
        send_host(2, 100, sent);
        wait_reports(base + 2, 200, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || rep_src[base+1] !== 1'b0 || rep_err[base+1] !== 1'b1 || rep_bytes[base+1] !== 8'd2) begin
            errors++;
            $display("FAIL host_err_report: ok=%b src=%b err=%b bytes=%0d expected 1 0 1 2",
                     ok, rep_src[base+1], rep_err[base+1], rep_bytes[base+1]);
        end
        checks++;
        if (rst_cycles != 2) begin
            errors++; $display("FAIL host_err_acc_reset: got %0d expected 2", rst_cycles);
        end
        $display("test_host_command error: sent=%0d", sent);
    endtask

    task automatic test_round_robin();
        int hs, bs, base; bit ok;
        apply_reset();
        clear_stats(-1);
        base = rep_cnt;
        host_buf[0] = 8'h31; host_buf[1] = 8'hBE; host_buf[2] = 8'hEF;
        ble_buf[0] = 8'h61; ble_buf[1] = 8'h0D;
        fork
            send_host(3, 300, hs);
            send_ble(2, 300, bs);
        join
        wait_reports(base + 2, 300, ok);
        checks++;
        if (!ok || rep_src[base] !== 1'b0 || rep_src[base+1] !== 1'b1) begin
            errors++;
            $display("FAIL rr_order: ok=%b first=%b second=%b expected 1 0 1",
                     ok, rep_src[base], rep_src[base+1]);
        end
        checks++;
        if (rep_bytes[base] !== 8'd3 || rep_bytes[base+1] !== 8'd2 ||
            rep_err[base] !== 1'b0 || rep_err[base+1] !== 1'b0) begin
            errors++;
            $display("FAIL rr_reports: bytes=%0d,%0d err=%b,%b expected 3,2 0,0",
                     rep_bytes[base], rep_bytes[base+1], rep_err[base], rep_err[base+1]);
        end
        checks++;
        if (ready_bad != 0) begin
            errors++; $display("FAIL rr_ready_isolation: got %0d expected 0", ready_bad);
        end
        $display("test_round_robin: host_sent=%0d ble_sent=%0d", hs, bs);
    endtask

    task automatic test_byte_timeout();
        int sent, base, t0, elapsed; bit ok;
        clear_stats(1);
        base = rep_cnt;
        ble_buf[0] = 8'h41;
        send_ble(1, 100, sent);
        t0 = cyc;
        wait_reports(base + 1, 1200, ok);
        elapsed = cyc - t0;
        repeat (8) @(negedge clk);
        checks++;
        if (!ok || rep_err[base] !== 1'b1 || rep_bytes[base] !== 8'd1 || rep_src[base] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_report: ok=%b err=%b bytes=%0d src=%b expected 1 1 1 1",
                     ok, rep_err[base], rep_bytes[base], rep_src[base]);
        end
        checks++;
        if (elapsed < 1000 || elapsed > 1020) begin
            errors++; $display("FAIL timeout_latency: got %0d expected 1000..1020", elapsed);
        end
        checks++;
        if (rst_cycles != 2) begin
            errors++; $display("FAIL timeout_acc_reset: got %0d expected 2", rst_cycles);
        end
        $display("test_byte_timeout: elapsed=%0d", elapsed);
    endtask

    task automatic test_overflow();
        int sent, base, extra; bit ok;
        clear_stats(0);
        base = rep_cnt;
        for (int i = 0; i < 128; i++) host_buf[i] = 8'h30;
        send_host(128, 50, sent);
        host_byte = 8'h30; host_valid = 1'b1;
        extra = 0; ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (host_ready) extra++;
            if (rep_cnt > base) ok = 1'b1;
        end
        host_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (sent != 128 || !ok) begin
            errors++; $display("FAIL overflow_sent: sent=%0d report=%b expected 128 1", sent, ok);
        end
        checks++;
        if (rep_err[base] !== 1'b1 || rep_bytes[base] !== 8'd128 || rep_src[base] !== 1'b0) begin
            errors++;
            $display("FAIL overflow_report: err=%b bytes=%0d src=%b expected 1 128 0",
                     rep_err[base], rep_bytes[base], rep_src[base]);
        end
        checks++;
        if (extra != 0 || pulse_cnt != 128) begin
            errors++; $display("FAIL overflow_129th: ready_cycles=%0d pulses=%0d expected 0 128", extra, pulse_cnt);
        end
        $display("test_overflow: sent=%0d", sent);
    endtask

    task automatic test_backpressure_and_reset();
        int sent, base, unstable; bit ok;
        clear_stats(-1);
        base = rep_cnt;
        cmd_ready = 1'b0;
        ble_buf[0] = 8'h41; ble_buf[1] = 8'h0D;
        send_ble(2, 100, sent);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (cmd_valid) ok = 1'b1;
        end
        host_byte = 8'h11; host_valid = 1'b1;
        unstable = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cmd_valid !== 1'b1 || cmd_source !== 1'b1 || cmd_error !== 1'b0 ||
                cmd_bytes !== 8'd2 || host_ready !== 1'b0 || busy !== 1'b1) unstable++;
        end
        checks++;
        if (!ok || unstable != 0) begin
            errors++; $display("FAIL bp_hold: seen=%b unstable_cycles=%0d expected 1 0", ok, unstable);
        end
        @(posedge clk); #1 cmd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || rep_cnt != base + 1) begin
            errors++; $display("FAIL bp_release: cmd_valid=%b reports=%0d expected 0 %0d",
                               cmd_valid, rep_cnt - base, 1);
        end
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (acc_accumulate) ok = 1'b1;
        end
        checks++;
        if (!ok || acc_ble_side !== 1'b0) begin
            errors++; $display("FAIL bp_host_grant: pulse=%b side=%b expected 1 0", ok, acc_ble_side);
        end
        reset = 1'b1; host_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (all_outs !== 25'd0) begin
            errors++; $display("FAIL midcmd_reset_outputs: got %h expected 0", all_outs);
        end
        @(posedge clk); #1 reset = 1'b0;
        rst_cycles = 0;
        repeat (12) @(negedge clk);
        checks++;
        if (rst_cycles != 2 || rep_cnt != base + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midcmd_recovery: acc_reset=%0d reports=%0d busy=%b expected 2 1 0",
                     rst_cycles, rep_cnt - base, busy);
        end
        $display("test_backpressure_and_reset: unstable=%0d", unstable);
    endtask

    initial begin
        test_reset();
        test_ble_command();
        test_host_command();
        test_round_robin();
        test_byte_timeout();
        test_overflow();
        test_backpressure_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
